// File: rtl/mesh_traffic_ctrl_pkg.sv
// Shared constants, types and destination helper for the mesh traffic controller.
// The optional RUN-phase watchdog is enabled by defining MESH_TC_TIMEOUT_EN.
package mesh_traffic_ctrl_pkg;

  localparam int unsigned NumPe  = 8;
  localparam int unsigned SendW  = 3;
  localparam int unsigned RecvW  = 3;
  localparam int unsigned RateW  = 4;
  localparam int unsigned DstW   = 24;
  localparam int unsigned ModeW  = 4;
  localparam int unsigned DstIdW = 3;

  typedef enum logic [2:0] {
    PatComplement = 3'd0,
    PatReverse    = 3'd1,
    PatRotation   = 3'd2,
    PatShuffle    = 3'd3,
    PatTornado    = 3'd4,
    PatNeighbor   = 3'd5,
    PatHotspot    = 3'd6,
    PatTurn       = 3'd7
  } pattern_e;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StSettle,
    StRun,
    StDone
  } state_e;

  // Hotspot and turn traffic all converge on PE0, hence the zero default.
  function automatic logic [DstIdW-1:0] patternDest(input pattern_e pat,
                                                    input logic [DstIdW-1:0] pe);
    logic [DstIdW-1:0] dest;
    case (pat)
      PatComplement: dest = ~pe;
      PatReverse:    dest = {pe[0], pe[1], pe[2]};
      PatRotation:   dest = {pe[0], pe[2:1]};
      PatShuffle:    dest = {pe[1:0], pe[2]};
      PatTornado:    dest = pe + 3'd3;
      PatNeighbor:   dest = pe + 3'd1;
      default:       dest = '0;
    endcase
    return dest;
  endfunction

endpackage

// File: rtl/mesh_pattern_lut.sv
// Combinational traffic-pattern table: maps a pattern code onto the per-PE
// configuration buses that the controller registers at test start.
module mesh_pattern_lut
  import mesh_traffic_ctrl_pkg::*;
(
  input  logic [2:0]            pattern_sel_i,
  output logic [NumPe-1:0]      dbg_mode_o,
  output logic [NumPe*SendW-1:0] send_num_o,
  output logic [NumPe*RecvW-1:0] receive_num_o,
  output logic [NumPe*RateW-1:0] rate_o,
  output logic [NumPe*DstW-1:0]  dst_seq_o,
  output logic [NumPe*ModeW-1:0] mode_o
);

  pattern_e pat;
  assign pat = pattern_e'(pattern_sel_i);

  always_comb begin
    dbg_mode_o    = '1;
    rate_o        = '0;
    send_num_o    = '0;
    receive_num_o = '0;
    dst_seq_o     = '0;
    mode_o        = '0;
    for (int i = 0; i < NumPe; i++) begin
      dst_seq_o[DstW*i +: DstW] = DstW'(patternDest(pat, DstIdW'(i)));
      case (pat)
        PatHotspot: begin
          send_num_o[SendW*i +: SendW]    = (i == 0) ? 3'd0 : 3'd1;
          receive_num_o[RecvW*i +: RecvW] = (i == 0) ? 3'd7 : 3'd0;
          mode_o[ModeW*i +: ModeW]        = 4'b0001;
        end
        PatTurn: begin
          send_num_o[SendW*i +: SendW]    = 3'd7;
          receive_num_o[RecvW*i +: RecvW] = 3'd7;
          mode_o[ModeW*i +: ModeW]        = 4'b0000;
        end
        default: begin
          send_num_o[SendW*i +: SendW]    = 3'd1;
          receive_num_o[RecvW*i +: RecvW] = 3'd1;
          mode_o[ModeW*i +: ModeW]        = 4'b0001;
        end
      endcase
    end
  end

endmodule

// File: rtl/mesh_traffic_ctrl.sv
// Test sequencer for the PE mesh: flush, settle, run until all PEs finish, report.
// Defining MESH_TC_TIMEOUT_EN adds a RUN-phase watchdog of TIMEOUT_CYCLES.
module mesh_traffic_ctrl
  import mesh_traffic_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES  = 100,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   pattern_sel,
  input  logic [7:0]   pe_task_send_finish_flag,
  input  logic [7:0]   pe_task_receive_finish_flag,
  output logic [7:0]   pe_enable,
  output logic [7:0]   pe_dbg_mode_wire,
  output logic [23:0]  pe_send_num_wire,
  output logic [23:0]  pe_receive_num_wire,
  output logic [31:0]  pe_rate_wire,
  output logic [191:0] pe_dst_seq_wire,
  output logic [31:0]  pe_mode_wire,
  output logic [7:0]   pe_flush_wire,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [31:0]  cycle_count
);

  state_e         state_q;
  logic [31:0]    phase_q;
  logic [31:0]    cycle_q;
  logic [31:0]    cycle_d;
  logic [7:0]     enable_q;
  logic [7:0]     flush_q;
  logic           busy_q;
  logic           done_q;
  logic           timeout_q;
  logic [7:0]     dbg_q;
  logic [23:0]    send_q;
  logic [23:0]    recv_q;
  logic [31:0]    rate_q;
  logic [191:0]   dst_q;
  logic [31:0]    mode_q;

  logic [7:0]     lutDbg;
  logic [23:0]    lutSend;
  logic [23:0]    lutRecv;
  logic [31:0]    lutRate;
  logic [191:0]   lutDst;
  logic [31:0]    lutMode;
  logic           allFinished;
  logic           watchdogHit;

  mesh_pattern_lut u_lut (
    .pattern_sel_i (pattern_sel),
    .dbg_mode_o    (lutDbg),
    .send_num_o    (lutSend),
    .receive_num_o (lutRecv),
    .rate_o        (lutRate),
    .dst_seq_o     (lutDst),
    .mode_o        (lutMode)
  );

  assign cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
  assign allFinished = (pe_task_send_finish_flag == '1) && (pe_task_receive_finish_flag == '1);

`ifdef MESH_TC_TIMEOUT_EN
  assign watchdogHit = (cycle_d >= TIMEOUT_CYCLES);
`else
  localparam int unsigned unusedTimeoutCycles = TIMEOUT_CYCLES;
  assign watchdogHit = 1'b0;
`endif

  // Completion is tested first so a coincident watchdog hit still reports success.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      cycle_q   <= '0;
      enable_q  <= '0;
      flush_q   <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      dbg_q     <= '0;
      send_q    <= '0;
      recv_q    <= '0;
      rate_q    <= '0;
      dst_q     <= '0;
      mode_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StFlush;
            phase_q   <= '0;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            dbg_q     <= lutDbg;
            send_q    <= lutSend;
            recv_q    <= lutRecv;
            rate_q    <= lutRate;
            dst_q     <= lutDst;
            mode_q    <= lutMode;
          end
        end
        StFlush: begin
          if (phase_q == FLUSH_CYCLES - 1) begin
            state_q <= StSettle;
            phase_q <= '0;
            flush_q <= '0;
          end else begin
            phase_q <= phase_q + 32'd1;
          end
        end
        StSettle: begin
          if (phase_q == SETTLE_CYCLES - 1) begin
            state_q  <= StRun;
            phase_q  <= '0;
            cycle_q  <= '0;
            enable_q <= '1;
          end else begin
            phase_q <= phase_q + 32'd1;
          end
        end
        StRun: begin
          cycle_q <= cycle_d;
          if (allFinished || watchdogHit) begin
            state_q   <= StDone;
            enable_q  <= '0;
            flush_q   <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= !allFinished;
          end
        end
        StDone: begin
          if (!start) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pe_enable           = enable_q;
  assign pe_flush_wire       = flush_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign timeout             = timeout_q;
  assign cycle_count         = cycle_q;
  assign pe_dbg_mode_wire    = dbg_q;
  assign pe_send_num_wire    = send_q;
  assign pe_receive_num_wire = recv_q;
  assign pe_rate_wire        = rate_q;
  assign pe_dst_seq_wire     = dst_q;
  assign pe_mode_wire        = mode_q;

endmodule

// File: tb/tb_mesh_traffic_ctrl.sv
// Self-checking bench for mesh_traffic_ctrl: directed scenarios plus randomized runs
// against a pattern reference model. Watchdog checks depend on MESH_TC_TIMEOUT_EN.
module tb_mesh_traffic_ctrl;

  localparam int FlushCycles   = 4;
  localparam int SettleCycles  = 100;
  localparam int TimeoutCycles = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   pattern_sel = 3'd0;
  logic [7:0]   sendFlags = 8'h00;
  logic [7:0]   recvFlags = 8'h00;
  logic [7:0]   pe_enable;
  logic [7:0]   pe_dbg_mode_wire;
  logic [23:0]  pe_send_num_wire;
  logic [23:0]  pe_receive_num_wire;
  logic [31:0]  pe_rate_wire;
  logic [191:0] pe_dst_seq_wire;
  logic [31:0]  pe_mode_wire;
  logic [7:0]   pe_flush_wire;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [31:0]  cycle_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mesh_traffic_ctrl #(
    .FLUSH_CYCLES   (FlushCycles),
    .SETTLE_CYCLES  (SettleCycles),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .start                       (start),
    .pattern_sel                 (pattern_sel),
    .pe_task_send_finish_flag    (sendFlags),
    .pe_task_receive_finish_flag (recvFlags),
    .pe_enable                   (pe_enable),
    .pe_dbg_mode_wire            (pe_dbg_mode_wire),
    .pe_send_num_wire            (pe_send_num_wire),
    .pe_receive_num_wire         (pe_receive_num_wire),
    .pe_rate_wire                (pe_rate_wire),
    .pe_dst_seq_wire             (pe_dst_seq_wire),
    .pe_mode_wire                (pe_mode_wire),
    .pe_flush_wire               (pe_flush_wire),
    .busy                        (busy),
    .done                        (done),
    .timeout                     (timeout),
    .cycle_count                 (cycle_count)
  );

  // Destination of PE i written directly from the pattern definitions.
  function automatic int refDest(input int sel, input int i);
    case (sel)
      0: return 7 - i;
      1: return (i % 2) * 4 + ((i / 2) % 2) * 2 + (i / 4);
      2: return (i / 2) + (i % 2) * 4;
      3: return ((i * 2) % 8) + (i / 4);
      4: return (i + 3) % 8;
      5: return (i + 1) % 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [191:0] refDstBus(input int sel);
    logic [191:0] bus = '0;
    for (int i = 0; i < 8; i++) bus[24*i +: 24] = 24'(refDest(sel, i));
    return bus;
  endfunction

  function automatic logic [23:0] refSendBus(input int sel);
    logic [23:0] bus = '0;
    for (int i = 0; i < 8; i++) begin
      int v;
      if (sel == 6) v = (i == 0) ? 0 : 1;
      else if (sel == 7) v = 7;
      else v = 1;
      bus[3*i +: 3] = 3'(v);
    end
    return bus;
  endfunction

  function automatic logic [23:0] refRecvBus(input int sel);
    logic [23:0] bus = '0;
    for (int i = 0; i < 8; i++) begin
      int v;
      if (sel == 6) v = (i == 0) ? 7 : 0;
      else if (sel == 7) v = 7;
      else v = 1;
      bus[3*i +: 3] = 3'(v);
    end
    return bus;
  endfunction

  function automatic logic [31:0] refModeBus(input int sel);
    logic [31:0] bus = '0;
    for (int i = 0; i < 8; i++) bus[4*i +: 4] = (sel == 7) ? 4'b0000 : 4'b0001;
    return bus;
  endfunction

  task automatic checkOutput(input string tag, input logic [191:0] observed,
                             input logic [191:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkConfig(input string tag, input int sel);
    checkOutput({tag, ".dbg"},  192'(pe_dbg_mode_wire),    192'(8'hFF));
    checkOutput({tag, ".rate"}, 192'(pe_rate_wire),        192'(0));
    checkOutput({tag, ".send"}, 192'(pe_send_num_wire),    192'(refSendBus(sel)));
    checkOutput({tag, ".recv"}, 192'(pe_receive_num_wire), 192'(refRecvBus(sel)));
    checkOutput({tag, ".mode"}, 192'(pe_mode_wire),        192'(refModeBus(sel)));
    checkOutput({tag, ".dst"},  pe_dst_seq_wire,           refDstBus(sel));
  endtask

  // Runs one test from IDLE; returns in DONE (start still high) or, if no
  // completion is expected, still in RUN after maxRun cycles.
  task automatic applyStimulus(input int sel, input int flagDelay, input int midSel,
                               input int maxRun);
    int n;
    int compCycle;
    int expCount;
    bit expTimeout;
    int runCycles;
    int kind;
    logic [7:0] partial;
    pattern_sel = 3'(sel);
    start = 1'b1;
    sendFlags = 8'h00;
    recvFlags = 8'h00;
    @(negedge clk);
    checkOutput("startBusy", 192'(busy), 192'(1));
    checkConfig("flush", sel);
    n = 0;
    while (pe_flush_wire === 8'hFF && busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("flushLen", 192'(n), 192'(FlushCycles));
    n = 0;
    while (pe_flush_wire === 8'h00 && pe_enable === 8'h00 && n < 500) begin
      if (midSel >= 0 && n == SettleCycles / 2) pattern_sel = 3'(midSel);
      n++;
      @(negedge clk);
    end
    checkOutput("settleLen", 192'(n), 192'(SettleCycles));
    checkOutput("runEnable", 192'(pe_enable), 192'(8'hFF));
    checkOutput("runCountStart", 192'(cycle_count), 192'(0));
    checkConfig("run", sel);

    compCycle  = (flagDelay >= 0) ? flagDelay + 1 : -1;
    expCount   = compCycle;
    expTimeout = 1'b0;
`ifdef MESH_TC_TIMEOUT_EN
    if (compCycle < 0 || compCycle > TimeoutCycles) begin
      expTimeout = 1'b1;
      expCount   = TimeoutCycles;
    end
`endif

    runCycles = 0;
    while (done !== 1'b1 && runCycles < maxRun) begin
      if (runCycles == flagDelay) begin
        sendFlags = 8'hFF;
        recvFlags = 8'hFF;
      end else begin
        kind    = int'($urandom_range(0, 2));
        partial = 8'($urandom) & ~(8'h01 << $urandom_range(0, 7));
        sendFlags = (kind == 0) ? 8'hFF : partial;
        recvFlags = (kind == 1) ? 8'hFF : (partial ^ 8'h5A) & ~(8'h01 << $urandom_range(0, 7));
      end
      @(negedge clk);
      runCycles++;
    end
    sendFlags = 8'h00;
    recvFlags = 8'h00;

    if (expCount < 0) begin
      checkOutput("hangDone",    192'(done),        192'(0));
      checkOutput("hangCount",   192'(cycle_count), 192'(maxRun));
      checkOutput("hangTimeout", 192'(timeout),     192'(0));
      checkOutput("hangEnable",  192'(pe_enable),   192'(8'hFF));
    end else begin
      checkOutput("doneFlag",    192'(done),          192'(1));
      checkOutput("doneBusy",    192'(busy),          192'(0));
      checkOutput("doneEnable",  192'(pe_enable),     192'(0));
      checkOutput("doneFlush",   192'(pe_flush_wire), 192'(8'hFF));
      checkOutput("doneTimeout", 192'(timeout),       192'(expTimeout));
      checkOutput("doneCount",   192'(cycle_count),   192'(expCount));
      checkConfig("done", sel);
      repeat (3) @(negedge clk);
      checkOutput("doneHeld",  192'(done),        192'(1));
      checkOutput("countHeld", 192'(cycle_count), 192'(expCount));
    end
  endtask

  task automatic releaseStart();
    start = 1'b0;
    @(negedge clk);
    checkOutput("idleDone",   192'(done),          192'(0));
    checkOutput("idleBusy",   192'(busy),          192'(0));
    checkOutput("idleEnable", 192'(pe_enable),     192'(0));
    checkOutput("idleFlush",  192'(pe_flush_wire), 192'(8'hFF));
  endtask

  task automatic resetPulse();
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rstEnable",  192'(pe_enable),        192'(0));
    checkOutput("rstFlush",   192'(pe_flush_wire),    192'(8'hFF));
    checkOutput("rstBusy",    192'(busy),             192'(0));
    checkOutput("rstDone",    192'(done),             192'(0));
    checkOutput("rstTimeout", 192'(timeout),          192'(0));
    checkOutput("rstCount",   192'(cycle_count),      192'(0));
    checkOutput("rstDbg",     192'(pe_dbg_mode_wire), 192'(0));
    checkOutput("rstSend",    192'(pe_send_num_wire), 192'(0));
    checkOutput("rstDst",     pe_dst_seq_wire,        192'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstStayIdle", 192'(busy), 192'(0));
  endtask

  task automatic abortWithReset(input int sel);
    int n;
    pattern_sel = 3'(sel);
    start = 1'b1;
    n = 0;
    while (pe_enable !== 8'hFF && n < 300) begin
      n++;
      @(negedge clk);
    end
    checkOutput("abortReachRun", 192'(pe_enable), 192'(8'hFF));
    repeat (3) @(negedge clk);
    resetPulse();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL simTimeLimit observed=expired required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int tornado [8] = '{3, 4, 5, 6, 7, 0, 1, 2};
    int sel;
    int other;
    repeat (3) @(negedge clk);
    checkOutput("resetEnable", 192'(pe_enable),        192'(0));
    checkOutput("resetFlush",  192'(pe_flush_wire),    192'(8'hFF));
    checkOutput("resetBusy",   192'(busy),             192'(0));
    checkOutput("resetDone",   192'(done),             192'(0));
    checkOutput("resetCount",  192'(cycle_count),      192'(0));
    checkOutput("resetDbg",    192'(pe_dbg_mode_wire), 192'(0));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 5, -1, 200);
    checkOutput("p0Slot0", 192'(pe_dst_seq_wire[0 +: 24]),   192'(7));
    checkOutput("p0Slot7", 192'(pe_dst_seq_wire[168 +: 24]), 192'(0));
    checkOutput("p0Count", 192'(cycle_count), 192'(6));
    releaseStart();

    applyStimulus(6, 2, 1, 200);
    checkOutput("hotSend", 192'(pe_send_num_wire),    192'(24'o11111110));
    checkOutput("hotRecv", 192'(pe_receive_num_wire), 192'(24'o00000007));
    checkOutput("hotDst",  pe_dst_seq_wire,           192'(0));
    releaseStart();

    applyStimulus(4, 0, 7, 200);
    for (int i = 0; i < 8; i++)
      checkOutput("tornadoDst", 192'(pe_dst_seq_wire[24*i +: 24]), 192'(tornado[i]));
    releaseStart();

    applyStimulus(2, 3, -1, 200);
    checkOutput("rotPe1", 192'(pe_dst_seq_wire[24 +: 24]),  192'(4));
    checkOutput("rotPe6", 192'(pe_dst_seq_wire[144 +: 24]), 192'(3));
    releaseStart();

    for (int k = 0; k < 8; k++) begin
      sel   = int'($urandom_range(0, 7));
      other = (sel + int'($urandom_range(1, 7))) % 8;
      applyStimulus(sel, int'($urandom_range(0, 30)), other, 200);
      releaseStart();
    end

    applyStimulus(5, -1, -1, 300);
`ifdef MESH_TC_TIMEOUT_EN
    releaseStart();
`else
    resetPulse();
`endif

    abortWithReset(3);
    applyStimulus(1, 4, -1, 200);
    releaseStart();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
